instr_mem_loader: RTL and testbench

Writer-side companion to the byte-addressed instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes them into the memory's byte array, one byte per cycle, in big-endian order. Byte 0 is bits [31:24] at the lowest address, matching how the fetch side concatenates four consecutive bytes into an instruction. It sits between the program-load source (test harness or boot path) and the instruction memory write port, and runs only while the core is held idle.

---
 rtl/instr_mem_loader_pkg.sv | 28 ++
 rtl/instr_mem_loader_serializer.sv | 58 +++++
 rtl/instr_mem_loader.sv | 133 +++++++++++++
 tb/tb_instr_mem_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader and the fetch side:
// FSM state encoding, default memory size and big-endian byte selection.
package instr_mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 1024;
    localparam int CNT_W_DEFAULT     = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WAIT_WORD = 2'd1;
    localparam state_t ST_WRITE     = 2'd2;
    localparam state_t ST_DONE      = 2'd3;

    // Byte 0 is the most significant byte, stored at the lowest address.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        b = word[7:0];
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instr_mem_loader_serializer.sv
// Holds one captured instruction word and emits its four bytes, MSB first,
// one per cycle; the byte output is registered and holds after the last byte.
module word_byte_serializer
    import instr_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    output logic [7:0]  out_byte,
    output logic [1:0]  idx,
    output logic        last
);

    logic [31:0] hold_q, hold_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        active_q, active_d;

    always_comb begin
        hold_d   = hold_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        active_d = active_q;
        if (load) begin
            hold_d   = word;
            idx_d    = 2'd0;
            byte_d   = be_byte(word, 2'd0);
            active_d = 1'b1;
        end else if (active_q) begin
            if (idx_q == 2'd3) begin
                active_d = 1'b0;
            end else begin
                idx_d  = idx_q + 2'd1;
                byte_d = be_byte(hold_q, idx_q + 2'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q   <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            active_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            active_q <= active_d;
        end
    end

    assign out_byte = byte_q;
    assign idx      = idx_q;
    assign last     = active_q && (idx_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads 32-bit instruction words from a valid/ready stream into the byte-wide
// instruction memory, big-endian, one byte per cycle, with bounds checking.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] loaded_words,
    output logic [1:0]       dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // The source must hold in_data stable while in_valid is high and in_ready low.

    state_t           state_q, state_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] loaded_q, loaded_d;
    logic             err_q, err_d;

    logic             ser_load;
    logic [7:0]       ser_byte;
    logic [1:0]       ser_idx;
    logic             ser_last;
    logic [33:0]      end_addr;
    logic [CNT_W-1:0] loaded_inc;

    word_byte_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .word     (in_data),
        .out_byte (ser_byte),
        .idx      (ser_idx),
        .last     (ser_last)
    );

    // Session end address evaluated wide enough that it can never wrap.
    assign end_addr   = {2'b00, base_addr} + {{(32-CNT_W){1'b0}}, word_count, 2'b00};
    assign loaded_inc = loaded_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        mem_addr_d = mem_addr_q;
        count_d    = count_q;
        loaded_d   = loaded_q;
        err_d      = err_q;
        ser_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d = base_addr;
                    count_d    = word_count;
                    loaded_d   = '0;
                    err_d      = 1'b0;
                    if ((base_addr[1:0] != 2'b00) || (end_addr > 34'(MEM_BYTES))) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (word_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_WORD;
                    end
                end
            end
            ST_WAIT_WORD: begin
                if (in_valid && in_ready) begin
                    ser_load   = 1'b1;
                    mem_addr_d = cur_addr_q;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ser_last) begin
                    cur_addr_d = cur_addr_q + 32'd4;
                    loaded_d   = loaded_inc;
                    state_d    = (loaded_inc == count_q) ? ST_DONE : ST_WAIT_WORD;
                end else begin
                    mem_addr_d = cur_addr_q + {30'd0, ser_idx} + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            mem_addr_q <= '0;
            count_q    <= '0;
            loaded_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            loaded_q   <= loaded_d;
            err_q      <= err_d;
        end
    end

    assign in_ready     = (state_q == ST_WAIT_WORD);
    assign busy         = (state_q == ST_WAIT_WORD) || (state_q == ST_WRITE);
    assign done         = (state_q == ST_DONE);
    assign mem_we       = (state_q == ST_WRITE);
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = ser_byte;
    assign err          = err_q;
    assign loaded_words = loaded_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized checks of instr_mem_loader against a session-level
// model: expected byte writes, handshake timing, bounds rejects and reset.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] loaded_words;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] exp_q[$];
    logic [7:0]  mem_img[0:1023];
    logic [31:0] cur_addr_m;
    logic [15:0] loaded_m;

    instr_mem_loader #(.MEM_BYTES(1024), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .loaded_words (loaded_words),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every byte write must match the head of the expected queue
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {63'd0, mem_we}, 64'd0);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {32'd0, mem_addr}, {32'd0, e[39:8]});
                check("wr_data", {56'd0, mem_wdata}, {56'd0, e[7:0]});
            end
            if (mem_addr < 32'd1024) mem_img[mem_addr[9:0]] = mem_wdata;
        end
    end

    // drivers
    task automatic start_session(input logic [31:0] base, input logic [15:0] cnt, output bit acc);
        bit rej;
        @(negedge clk);
        in_valid   = 1'b0;
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        @(negedge clk);
        start = 1'b0;
        rej = (base % 4 != 0) || (longint'(base) + 4 * longint'(cnt) > 1024);
        acc = !rej && (cnt != 0);
        cur_addr_m = base;
        loaded_m   = '0;
        check("start_busy", {63'd0, busy}, {63'd0, acc});
        check("start_ready", {63'd0, in_ready}, {63'd0, acc});
        check("start_done", {63'd0, done}, {63'd0, !acc});
        check("start_err", {63'd0, err}, {63'd0, rej});
        if (!acc) begin
            check("start_loaded", {48'd0, loaded_words}, 64'd0);
            @(negedge clk);
            check("rej_done_pulse", {63'd0, done}, 64'd0);
            check("rej_idle", {62'd0, dbg_state}, 64'd0);
            check("rej_err_held", {63'd0, err}, {63'd0, rej});
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit last,
                             input bit keep_valid, input bit poke_start);
        int waited;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            check("gap_ready", {63'd0, in_ready}, 64'd1);
            check("gap_we", {63'd0, mem_we}, 64'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++)
            exp_q.push_back({cur_addr_m + 32'(i), 8'(w >> (24 - 8 * i))});
        in_valid = 1'b1;
        in_data  = w;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("hs_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready !== 1'b1) return;
        @(negedge clk);
        in_valid = keep_valid;
        for (int k = 1; k <= 4; k++) begin
            check("wr_we", {63'd0, mem_we}, 64'd1);
            check("wr_no_ready", {63'd0, in_ready}, 64'd0);
            if (poke_start && k == 2) begin
                start      = 1'b1;
                base_addr  = 32'h10;
                word_count = 16'd5;
            end
            if (k == 3) start = 1'b0;
            @(negedge clk);
        end
        cur_addr_m += 32'd4;
        loaded_m   += 16'd1;
        check("end_done", {63'd0, done}, {63'd0, last});
        check("end_busy", {63'd0, busy}, {63'd0, !last});
        check("end_ready", {63'd0, in_ready}, {63'd0, !last});
        check("end_loaded", {48'd0, loaded_words}, {48'd0, loaded_m});
        check("end_err", {63'd0, err}, 64'd0);
        if (last) begin
            @(negedge clk);
            check("done_pulse", {63'd0, done}, 64'd0);
            check("idle_state", {62'd0, dbg_state}, 64'd0);
            check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_we"}, {63'd0, mem_we}, 64'd0);
        check({tag, "_addr"}, {32'd0, mem_addr}, 64'd0);
        check({tag, "_wdata"}, {56'd0, mem_wdata}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
        check({tag, "_loaded"}, {48'd0, loaded_words}, 64'd0);
        check({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
    endtask

    initial begin
        bit acc;
        logic [31:0] fetched;
        logic [31:0] rbase;
        int rcnt;

        rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst = 1'b1;

        // reset in the middle of a word: two bytes land, nothing is counted
        start_session(32'h100, 16'd2, acc);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({32'h100 + 32'(i), 8'(32'h11223344 >> (24 - 8 * i))});
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        check("midrst_b0", {56'd0, mem_img[10'h100]}, 64'h11);
        check("midrst_b1", {56'd0, mem_img[10'h101]}, 64'h22);

        // single word
        start_session(32'h0, 16'd1, acc);
        send_word(32'hE3A00014, 0, 1'b1, 1'b0, 1'b0);

        // three-word stream with in_valid held high
        start_session(32'h40, 16'd3, acc);
        send_word(32'hE3A00014, 0, 1'b0, 1'b1, 1'b0);
        send_word(32'hE3A01A01, 0, 1'b0, 1'b1, 1'b0);
        send_word(32'hE0923002, 0, 1'b1, 1'b0, 1'b0);
        fetched = {instr_mem_pkg::be_byte(32'h0, 2'd0), 24'd0};
        fetched = {mem_img[10'h44], mem_img[10'h45], mem_img[10'h46], mem_img[10'h47]};
        check("fetch_0x44", {32'd0, fetched}, 64'hE3A01A01);

        // bounds and alignment
        start_session(32'h3FC, 16'd2, acc);
        start_session(32'h3FC, 16'd1, acc);
        send_word(32'hCAFEF00D, 1, 1'b1, 1'b0, 1'b0);
        start_session(32'h2, 16'd1, acc);
        repeat (3) @(negedge clk);
        check("err_hold", {63'd0, err}, 64'd1);

        // zero count clears err
        start_session(32'h80, 16'd0, acc);

        // start during WRITE is ignored
        start_session(32'h80, 16'd2, acc);
        send_word(32'h01234567, 0, 1'b0, 1'b0, 1'b1);
        send_word(32'h89ABCDEF, 0, 1'b1, 1'b0, 1'b0);

        // backpressure: source idle for 7 cycles between words
        start_session(32'h200, 16'd2, acc);
        send_word(32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
        send_word(32'h0BADF00D, 7, 1'b1, 1'b0, 1'b0);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            rbase = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) rbase[1:0] = 2'b00;
            rcnt = $urandom_range(0, 4);
            start_session(rbase, 16'(rcnt), acc);
            if (acc) begin
                for (int i = 0; i < rcnt; i++)
                    send_word($urandom, $urandom_range(0, 3), i == rcnt - 1,
                              1'($urandom_range(0, 1)), 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
